rc_osc_freq_monitor: RTL and testbench
======================================

Name: rc_osc_freq_monitor

Overview:
Digital companion to the on-chip RC oscillator. It sequences the oscillator enable with a programmable warm-up delay, synchronises the raw asynchronous oscillator output into the system clock domain, and counts oscillator rising edges over a programmable window of system clock cycles. Each measured count is compared against low/high thresholds, producing an in-range flag and a sticky fault. It sits between the RC oscillator macro (drives its ena, samples its dout) and the SoC register block.

Parameters:
CNT_W, 16, width of edge counter, count output and thresholds
WIN_W, 16, width of window_len
SYNC_STAGES, 2, flops in osc_in synchroniser (minimum 2)
STARTUP_CYC, 1024, clk cycles from osc_ena rising to ready

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  level; 1 = oscillator enabled and block active
start  input  1  one-cycle request for a single measurement; honoured only in READY
cont  input  1  level; 1 = back-to-back measurements while in READY
window_len  input  WIN_W  measurement window in clk cycles; 0 treated as 1
thr_lo  input  CNT_W  inclusive lower count limit
thr_hi  input  CNT_W  inclusive upper count limit
fault_clr  input  1  one-cycle clear of sticky fault
osc_in  input  1  raw oscillator output (asynchronous to clk)
osc_ena  output  1  oscillator enable
ready  output  1  warm-up complete, idle
busy  output  1  measurement in progress
count  output  CNT_W  last completed edge count
count_valid  output  1  one-cycle pulse when count updates
in_range  output  1  thr_lo <= count <= thr_hi for last count
fault  output  1  sticky: some completed count was out of range

Behaviour:
- Reset (rst_n low, async): state OFF; osc_ena=0, ready=0, busy=0, count=0, count_valid=0, in_range=0, fault=0; synchroniser and edge-detect flops cleared.
- Every output is registered.
- Synchroniser: SYNC_STAGES flops plus one previous-value flop. A rising edge is sync=1 and prev=1'b0. Runs in all states.
- Correct counting requires f_osc < f_clk/2; edge timing is shifted by SYNC_STAGES cycles, which is accepted.
- FSM states:
  - OFF: osc_ena=0. en=1 -> WARM.
  - WARM: osc_ena=1; warm counter runs STARTUP_CYC cycles, then -> READY, with ready=1 from the next cycle.
  - READY: ready=1. start=1 or cont=1 -> MEAS next cycle, with ready=0 and busy=1.
  - MEAS: window counter runs 0..max(window_len,1)-1 and the edge counter increments on each detected rising edge. window_len is sampled on entry to MEAS; changes during MEAS are ignored.
- Edge counter saturates at all-ones (2^CNT_W-1) and never wraps.
- Window end: on the last MEAS cycle, an edge detected in that same cycle is included. At the following clk edge:
  - count <= final count; count_valid=1 for one cycle; busy=0;
  - in_range <= (thr_lo <= count <= thr_hi), with thr_lo/thr_hi sampled at that edge;
  - state -> READY.
- Latency: start at cycle t -> MEAS cycles t+1..t+W -> count_valid at t+W+1.
- In cont mode READY lasts exactly one cycle between windows.
- thr_lo > thr_hi: in_range=0 always.
- fault set at window end when in_range evaluates 0. fault_clr clears it. If set and clear coincide, set wins.
- start while busy or not READY: ignored, no queuing.
- en=0 in any state: -> OFF next cycle; osc_ena=0, ready=0, busy=0.
  - A measurement in progress is aborted with no count_valid.
  - count, in_range and fault hold their values.
  - en re-asserted restarts the full warm-up.

Test Plan:
- clk 10 MHz, osc 500 kHz, STARTUP_CYC=16, en=1 -> osc_ena=1 next cycle, ready=1 exactly 17 cycles after en; start, window_len=200, thr 9..11 -> count_valid at start+201, count=10 (±1), in_range=1, fault=0.
- osc 400 kHz, same thresholds and window -> count=8, in_range=0, fault=1; fault stays 1 across a following in-range 500 kHz measurement; fault_clr -> fault=0 next cycle.
- CNT_W=4, osc at clk/4, window_len=100 -> count=15 (saturated, no wrap), in_range follows thresholds 0..15 -> 1.
- cont=1, window_len=50 -> count_valid pulses every 51 cycles; cont=0 mid-window -> current window completes, then FSM stays READY.
- en dropped at MEAS cycle 30 -> OFF next cycle, osc_ena=0, no count_valid, count holds previous value; en=1 -> full warm-up again. fault_clr coincident with an out-of-range result -> fault=1.
- rst_n low mid-MEAS (asynchronous, between clk edges) -> all outputs 0 immediately; window_len=0 -> 1-cycle window, count_valid two cycles after start.

Source files
------------

// File: rtl/rc_osc_freq_monitor.sv
// RC oscillator companion: enable sequencing with warm-up delay, osc_in
// synchronisation, and windowed edge counting with threshold checking.
module rc_osc_freq_monitor #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int STARTUP_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             cont,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic             fault_clr,
  input  logic             osc_in,
  output logic             osc_ena,
  output logic             ready,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             fault
);

  localparam int WARM_W = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(STARTUP_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WARM  = 2'd1,
    S_READY = 2'd2,
    S_MEAS  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   osc_ena_q, osc_ena_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   count_valid_q, count_valid_d;
  logic                   in_range_q, in_range_d;
  logic                   fault_q, fault_d;
  logic [WARM_W-1:0]      warm_cnt_q, warm_cnt_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]       win_last_q, win_last_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  logic                   rise;
  logic [CNT_W-1:0]       edge_next;
  logic                   range_ok;

  // Saturating increment: the edge counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Inclusive window check; an inverted window (lo > hi) never matches.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Rising edge of the synchronised oscillator, and the count including it.
  always_comb begin
    rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    edge_next = sat_inc(edge_cnt_q, rise);
    range_ok  = in_window(edge_next, thr_lo, thr_hi);
  end

  // Next-state logic for the sequencer, measurement counters and result flags.
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], osc_in};
    prev_d        = sync_q[SYNC_STAGES-1];
    state_d       = state_q;
    osc_ena_d     = osc_ena_q;
    ready_d       = ready_q;
    busy_d        = busy_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    in_range_d    = in_range_q;
    fault_d       = fault_q & ~fault_clr;
    warm_cnt_d    = warm_cnt_q;
    win_cnt_d     = win_cnt_q;
    win_last_d    = win_last_q;
    edge_cnt_d    = edge_cnt_q;

    if (!en) begin
      // Disabling drops everything back to OFF; results are left untouched.
      state_d   = S_OFF;
      osc_ena_d = 1'b0;
      ready_d   = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d    = S_WARM;
          osc_ena_d  = 1'b1;
          warm_cnt_d = '0;
        end
        S_WARM: begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d = S_READY;
            ready_d = 1'b1;
          end else begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
          end
        end
        S_READY: begin
          if (start || cont) begin
            state_d    = S_MEAS;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            win_last_d = (window_len == '0) ? '0 : window_len - WIN_W'(1);
          end
        end
        S_MEAS: begin
          if (win_cnt_q == win_last_q) begin
            // Last window cycle: publish the count including this cycle's edge.
            state_d       = S_READY;
            ready_d       = 1'b1;
            busy_d        = 1'b0;
            count_d       = edge_next;
            count_valid_d = 1'b1;
            in_range_d    = range_ok;
            if (!range_ok) fault_d = 1'b1;
          end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            edge_cnt_d = edge_next;
          end
        end
        default: begin
          state_d   = S_OFF;
          osc_ena_d = 1'b0;
          ready_d   = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // State, counters, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_OFF;
      osc_ena_q     <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      fault_q       <= 1'b0;
      warm_cnt_q    <= '0;
      win_cnt_q     <= '0;
      win_last_q    <= '0;
      edge_cnt_q    <= '0;
      sync_q        <= '0;
      prev_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      osc_ena_q     <= osc_ena_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      in_range_q    <= in_range_d;
      fault_q       <= fault_d;
      warm_cnt_q    <= warm_cnt_d;
      win_cnt_q     <= win_cnt_d;
      win_last_q    <= win_last_d;
      edge_cnt_q    <= edge_cnt_d;
      sync_q        <= sync_d;
      prev_q        <= prev_d;
    end
  end

  assign osc_ena     = osc_ena_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign in_range    = in_range_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_rc_osc_freq_monitor.sv
// Bench for rc_osc_freq_monitor: directed scenarios plus randomized windows,
// checked against a model built from the sampled oscillator history.
module tb_rc_osc_freq_monitor;

  localparam int CNT_W = 6;
  localparam int WIN_W = 16;
  localparam int SYNC  = 2;
  localparam int SC    = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             start;
  logic             cont;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] thr_lo;
  logic [CNT_W-1:0] thr_hi;
  logic             fault_clr;
  logic             osc_in;
  logic             osc_ena;
  logic             ready;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             in_range;
  logic             fault;

  int vectors     = 0;
  int miscompares = 0;
  int osc_half    = 1000;
  bit hist[$];

  bit exp_fault      = 1'b0;
  int exp_last_count = 0;
  bit exp_last_inr   = 1'b0;

  rc_osc_freq_monitor #(
    .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC), .STARTUP_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cont(cont),
    .window_len(window_len), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .fault_clr(fault_clr), .osc_in(osc_in), .osc_ena(osc_ena),
    .ready(ready), .busy(busy), .count(count), .count_valid(count_valid),
    .in_range(in_range), .fault(fault)
  );

  // Clock: posedges land on times ending in 0.
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Oscillator: toggles on times ending in 3, never on a clock edge.
  initial begin
    osc_in = 1'b0;
    #3;
    forever begin
      #(osc_half) osc_in = ~osc_in;
    end
  end

  // Record the oscillator level seen at every rising clock edge.
  always @(posedge clk) hist.push_back(osc_in);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising transitions of the sampled waveform seen during a window that
  // starts at edge t, delayed by the synchroniser depth, saturated.
  function automatic int ref_count(input int t, input int w);
    int n_rise = 0;
    for (int n = t; n < t + w; n++)
      if (hist[n - SYNC + 1] && !hist[n - SYNC]) n_rise++;
    return (n_rise > CMAX) ? CMAX : n_rise;
  endfunction

  task automatic check_result(input string tag, input int t, input int wef);
    int ec;
    bit ei;
    ec = ref_count(t, wef);
    ei = (ec >= int'(thr_lo)) && (ec <= int'(thr_hi));
    if (!ei) exp_fault = 1'b1;
    chk({tag, "_cv"},    64'(count_valid), 64'(1));
    chk({tag, "_count"}, 64'(count),       64'(ec));
    chk({tag, "_inr"},   64'(in_range),    64'(ei));
    chk({tag, "_fault"}, 64'(fault),       64'(exp_fault));
    exp_last_count = ec;
    exp_last_inr   = ei;
  endtask

  // One start-triggered measurement; poke re-pulses start mid-window.
  task automatic measure(input int w, input bit poke, input string tag);
    int t, ve, wef;
    bit seen;
    wef = (w == 0) ? 1 : w;
    window_len = WIN_W'(w);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t = hist.size() - 1;
    chk({tag, "_busy"},  64'(busy),  64'(1));
    chk({tag, "_ready"}, 64'(ready), 64'(0));
    seen = 1'b0;
    ve   = 0;
    for (int i = 0; i < wef + 5; i++) begin
      if (count_valid) begin
        seen = 1'b1;
        ve   = hist.size() - 1;
        break;
      end
      start = poke && (wef > 6) && (i == 2);
      tick(1);
    end
    start = 1'b0;
    chk({tag, "_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      chk({tag, "_lat"}, 64'(ve - t), 64'(wef));
      check_result(tag, t, wef);
      chk({tag, "_rdy_end"}, 64'(ready), 64'(1));
      tick(1);
      chk({tag, "_cv_pulse"}, 64'(count_valid), 64'(0));
      chk({tag, "_idle"},     64'(busy),        64'(0));
    end
  endtask

  initial begin
    int  v_prev, v_now, t;
    bit  seen, cv_any;
    int  lo, hi;

    rst_n = 1'b0; en = 1'b0; start = 1'b0; cont = 1'b0;
    window_len = WIN_W'(200); thr_lo = CNT_W'(9); thr_hi = CNT_W'(11);
    fault_clr = 1'b0;
    tick(3);

    // Reset state
    chk("rst_osc_ena", 64'(osc_ena),     64'(0));
    chk("rst_ready",   64'(ready),       64'(0));
    chk("rst_busy",    64'(busy),        64'(0));
    chk("rst_count",   64'(count),       64'(0));
    chk("rst_cv",      64'(count_valid), 64'(0));
    chk("rst_inr",     64'(in_range),    64'(0));
    chk("rst_fault",   64'(fault),       64'(0));
    rst_n = 1'b1;
    tick(2);

    // Warm-up timing
    en = 1'b1;
    tick(1);
    chk("warm_osc_ena", 64'(osc_ena), 64'(1));
    chk("warm_ready0",  64'(ready),   64'(0));
    tick(15);
    chk("warm_ready16", 64'(ready), 64'(0));
    tick(1);
    chk("warm_ready17", 64'(ready), 64'(1));

    // 500 kHz, in range
    tick(20);
    measure(200, 1'b0, "m500");
    chk("m500_exact", 64'(count), 64'(10));

    // 400 kHz, out of range, fault sticky
    osc_half = 1250;
    tick(40);
    measure(200, 1'b0, "m400");
    chk("m400_exact", 64'(count), 64'(8));
    chk("m400_fault", 64'(fault), 64'(1));
    osc_half = 1000;
    tick(40);
    measure(200, 1'b0, "m500b");
    chk("m500b_inr",   64'(in_range), 64'(1));
    chk("m500b_fault", 64'(fault),    64'(1));
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    exp_fault = 1'b0;
    chk("fclr", 64'(fault), 64'(0));

    // Inverted thresholds never match
    thr_lo = CNT_W'(12); thr_hi = CNT_W'(8);
    measure(200, 1'b0, "inv");
    chk("inv_inr", 64'(in_range), 64'(0));

    // Saturation at clk/4
    thr_lo = CNT_W'(0); thr_hi = CNT_W'(CMAX);
    osc_half = 200;
    tick(20);
    measure(400, 1'b1, "sat");
    chk("sat_max", 64'(count),    64'(CMAX));
    chk("sat_inr", 64'(in_range), 64'(1));

    // Continuous mode
    osc_half = 1000;
    tick(20);
    window_len = WIN_W'(50);
    cont = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (count_valid) begin seen = 1'b1; break; end
    end
    chk("cont_first", 64'(seen), 64'(1));
    v_prev = hist.size() - 1;
    check_result("cont0", v_prev - 50, 50);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        tick(20);
        cont = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        tick(1);
        if (count_valid) begin seen = 1'b1; break; end
      end
      chk("cont_seen", 64'(seen), 64'(1));
      v_now = hist.size() - 1;
      chk("cont_period", 64'(v_now - v_prev), 64'(51));
      check_result("contk", v_now - 50, 50);
      v_prev = v_now;
    end
    tick(3);
    chk("cont_stop_ready", 64'(ready),       64'(1));
    chk("cont_stop_busy",  64'(busy),        64'(0));
    chk("cont_stop_cv",    64'(count_valid), 64'(0));

    // Abort by en=0 at MEAS cycle 30
    window_len = WIN_W'(200);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(29);
    en = 1'b0;
    tick(1);
    chk("abort_osc_ena", 64'(osc_ena),  64'(0));
    chk("abort_busy",    64'(busy),     64'(0));
    chk("abort_ready",   64'(ready),    64'(0));
    chk("abort_count",   64'(count),    64'(exp_last_count));
    chk("abort_inr",     64'(in_range), 64'(exp_last_inr));
    chk("abort_fault",   64'(fault),    64'(exp_fault));
    cv_any = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (count_valid) cv_any = 1'b1;
    end
    chk("abort_no_cv", 64'(cv_any), 64'(0));
    chk("abort_hold",  64'(count),  64'(exp_last_count));
    en = 1'b1;
    tick(1);
    chk("rewarm_osc_ena", 64'(osc_ena), 64'(1));
    tick(15);
    chk("rewarm_ready16", 64'(ready), 64'(0));
    tick(1);
    chk("rewarm_ready17", 64'(ready), 64'(1));

    // fault_clr coincident with an out-of-range result: set wins
    thr_lo = CNT_W'(20); thr_hi = CNT_W'(30);
    window_len = WIN_W'(200);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t = hist.size() - 1;
    tick(199);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check_result("coinc", t, 200);
    chk("coinc_fault", 64'(fault), 64'(1));

    // Asynchronous reset mid-measurement
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    #20 rst_n = 1'b0;
    #1;
    chk("arst_osc_ena", 64'(osc_ena),     64'(0));
    chk("arst_ready",   64'(ready),       64'(0));
    chk("arst_busy",    64'(busy),        64'(0));
    chk("arst_count",   64'(count),       64'(0));
    chk("arst_cv",      64'(count_valid), 64'(0));
    chk("arst_inr",     64'(in_range),    64'(0));
    chk("arst_fault",   64'(fault),       64'(0));
    exp_fault = 1'b0; exp_last_count = 0; exp_last_inr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ready) begin seen = 1'b1; break; end
    end
    chk("arst_rewarm", 64'(seen), 64'(1));

    // Zero-length window behaves as one cycle
    thr_lo = CNT_W'(0); thr_hi = CNT_W'(1);
    tick(5);
    measure(0, 1'b0, "w0");

    // Randomized windows, frequencies and thresholds
    for (int r = 0; r < 8; r++) begin
      osc_half = 10 * int'($urandom_range(15, 120));
      lo = int'($urandom_range(0, CMAX));
      hi = int'($urandom_range(0, CMAX));
      thr_lo = CNT_W'(lo);
      thr_hi = CNT_W'(hi);
      tick(15);
      measure(int'($urandom_range(0, 300)), 1'b1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
